// File: rtl/ws2812_serializer.sv
// WS2812 NRZ serializer: continuously refreshes an LED chain from a colour word,
// snapshotting colordata once per frame at the end of the latch gap.
module ws2812_serializer #(
    parameter int unsigned N_LEDS  = 3,
    parameter int unsigned T0H     = 40,
    parameter int unsigned T1H     = 80,
    parameter int unsigned T_BIT   = 125,
    parameter int unsigned T_RESET = 6000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [24*N_LEDS-1:0]  colordata,
    output logic                  cled,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned NBITS = 24 * N_LEDS;
    localparam int unsigned GAP_W = $clog2(T_RESET);
    localparam int unsigned PH_W  = $clog2(T_BIT);
    localparam int unsigned IDX_W = $clog2(NBITS);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T_RESET - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(T_BIT - 1);
    localparam logic [PH_W-1:0]  T0H_L    = PH_W'(T0H);
    localparam logic [PH_W-1:0]  T1H_L    = PH_W'(T1H);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);

    typedef enum logic {
        ST_GAP,
        ST_SEND
    } state_t;

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PH_W-1:0]    phase;
    logic [IDX_W-1:0]   bit_idx;
    logic [NBITS-1:0]   shreg;
    logic [PH_W-1:0]    high_len;

    always_comb begin
        high_len = shreg[NBITS-1] ? T1H_L : T0H_L;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_GAP;
            gap_cnt    <= '0;
            phase      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            cled       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_GAP: begin
                    cled <= 1'b0;
                    busy <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        shreg   <= colordata;
                        bit_idx <= '0;
                        phase   <= '0;
                        gap_cnt <= '0;
                        state   <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    // Outputs lag phase by one edge, so each bit window stays exactly T_BIT wide.
                    cled <= (phase < high_len);
                    busy <= 1'b1;
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        shreg <= {shreg[NBITS-2:0], 1'b0};
                        if (bit_idx == IDX_LAST) begin
                            frame_done <= 1'b1;
                            gap_cnt    <= '0;
                            state      <= ST_GAP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= ST_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench for ws2812_serializer: captures cled/busy/frame_done per cycle
// and decodes the waveform against hand-computed words and cycle positions.
module tb_ws2812_serializer;

    logic        clk = 1'b0;
    logic        reset1, reset3;
    logic [23:0] colordata1;
    logic [71:0] colordata3;
    logic        cled1, busy1, fd1;
    logic        cled3, busy3, fd3;

    int errors = 0;
    int checks = 0;

    logic led_s [0:1023];
    logic busy_s[0:1023];
    logic fd_s  [0:1023];

    logic [71:0] word;
    int          bad;

    always #5 clk = ~clk;

    ws2812_serializer #(.N_LEDS(1), .T0H(2), .T1H(4), .T_BIT(6), .T_RESET(10)) dut1 (
        .clk(clk), .reset(reset1), .colordata(colordata1),
        .cled(cled1), .busy(busy1), .frame_done(fd1)
    );

    ws2812_serializer #(.N_LEDS(3), .T0H(2), .T1H(4), .T_BIT(6), .T_RESET(10)) dut3 (
        .clk(clk), .reset(reset3), .colordata(colordata3),
        .cled(cled3), .busy(busy3), .frame_done(fd3)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample index i holds the values registered at edge i (cycle 0 = first edge after release).
    task automatic capture(input int sel, input int n, input int sw_at, input logic [23:0] sw_val);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            led_s[i]  = sel ? cled3 : cled1;
            busy_s[i] = sel ? busy3 : busy1;
            fd_s[i]   = sel ? fd3   : fd1;
            if (i == sw_at) colordata1 = sw_val;
        end
    endtask

    function automatic logic pick(input int which, input int i);
        if (which == 0) return led_s[i];
        if (which == 1) return busy_s[i];
        return fd_s[i];
    endfunction

    function automatic int count_in(input int which, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (pick(which, i) === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_from(input int which, input int from, input int lim);
        for (int i = from; i < lim; i++) if (pick(which, i) === 1'b1) return i;
        return -1;
    endfunction

    // Each 6-cycle window must be a contiguous high run of 2 or 4 followed by low.
    task automatic decode(input int start, input int nbits, output logic [71:0] w, output int nbad);
        w = '0;
        nbad = 0;
        for (int k = 0; k < nbits; k++) begin
            int base = start + 6 * k;
            int h = 0;
            for (int j = 0; j < 6; j++) if (led_s[base + j] === 1'b1) h++;
            for (int j = 0; j < 6; j++) if (led_s[base + j] !== (j < h)) nbad++;
            if (h != 2 && h != 4) nbad++;
            w = {w[70:0], (h == 4)};
        end
    endtask

    task automatic restart1(input logic [23:0] val);
        @(negedge clk);
        reset1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        colordata1 = val;
        reset1 = 1'b1;
    endtask

    initial begin
        reset1 = 1'b0;
        reset3 = 1'b0;
        colordata1 = 24'h000000;
        colordata3 = {24'h00ff00, 24'h00ffff, 24'h000000};
        #12;
        check("rst_cled", cled1, 0);
        check("rst_busy", busy1, 0);
        check("rst_frame_done", fd1, 0);

        // all-zero word
        @(negedge clk);
        reset1 = 1'b1;
        capture(0, 170, -1, '0);
        check("t1_gap_low", count_in(0, 0, 9), 0);
        check("t1_first_high", first_from(0, 0, 170), 10);
        decode(10, 24, word, bad);
        check("t1_word", word, 72'h0);
        check("t1_shape", bad, 0);
        check("t1_busy_len", count_in(1, 0, 163), 144);
        check("t1_busy_first", first_from(1, 0, 170), 10);
        check("t1_done_count", count_in(2, 0, 163), 1);
        check("t1_done_pos", first_from(2, 0, 170), 153);
        check("t1_gap2_low", count_in(0, 154, 163), 0);
        check("t1_next_frame", led_s[164], 1);

        // MSB and LSB set
        restart1(24'h800001);
        capture(0, 160, -1, '0);
        decode(10, 24, word, bad);
        check("t2_word", word, 72'h800001);
        check("t2_shape", bad, 0);
        check("t2_bit0_high", count_in(0, 10, 15), 4);
        check("t2_bit1_high", count_in(0, 16, 21), 2);
        check("t2_bit23_high", count_in(0, 148, 153), 4);

        // colordata change at bit 5 must not tear the frame
        restart1(24'hFFFFFF);
        capture(0, 330, 42, 24'h000000);
        decode(10, 24, word, bad);
        check("t3_frame1_word", word, 72'hFFFFFF);
        check("t3_frame1_shape", bad, 0);
        decode(164, 24, word, bad);
        check("t3_frame2_word", word, 72'h000000);
        check("t3_frame2_shape", bad, 0);

        // three-LED chain
        @(negedge clk);
        reset3 = 1'b1;
        capture(1, 460, -1, '0);
        decode(10, 72, word, bad);
        check("t4_word", word, {24'h00ff00, 24'h00ffff, 24'h000000});
        check("t4_shape", bad, 0);
        check("t4_busy_len", count_in(1, 0, 451), 432);
        check("t4_done_pos", first_from(2, 0, 460), 441);
        check("t4_gap_low", count_in(0, 442, 451), 0);
        check("t4_period", first_from(0, 442, 460), 452);
        reset3 = 1'b0;

        // asynchronous reset during the high phase of bit 10
        restart1(24'h00FFFF);
        capture(0, 72, -1, '0);
        check("t5_bit10_high", cled1, 1);
        #2;
        reset1 = 1'b0;
        #1;
        check("t5_async_cled", cled1, 0);
        check("t5_async_busy", busy1, 0);
        @(negedge clk);
        @(negedge clk);
        reset1 = 1'b1;
        capture(0, 160, -1, '0);
        check("t5_gap_low", count_in(0, 0, 9), 0);
        check("t5_first_high", first_from(0, 0, 160), 10);
        decode(10, 24, word, bad);
        check("t5_word", word, 72'h00FFFF);
        check("t5_shape", bad, 0);
        check("t5_done_pos", first_from(2, 0, 160), 153);

        // three consecutive frames
        restart1(24'hA5C33C);
        capture(0, 475, -1, '0);
        for (int f = 0; f < 3; f++) begin
            int s = 10 + 154 * f;
            decode(s, 24, word, bad);
            check("t6_word", word, 72'hA5C33C);
            check("t6_shape", bad, 0);
            check("t6_busy_len", count_in(1, s, s + 143), 144);
            check("t6_gap_low", count_in(0, s + 144, s + 153), 0);
            check("t6_gap_busy", count_in(1, s + 144, s + 153), 0);
            check("t6_next_start", led_s[s + 154], 1);
            check("t6_done_pos", first_from(2, s, 475), s + 143);
        end
        check("t6_done_total", count_in(2, 0, 474), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
